// File: rtl/spi_pkg.sv
// Shared definitions for the byte-oriented SPI slave: byte width, mode-0
// clock constants, the frame state type and the default idle TX byte.
package spi_pkg;

  localparam int SPI_BYTE_W = 8;

  // Mode 0: clock idles low, data captured on the rising edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  localparam logic [SPI_BYTE_W-1:0] SPI_DEFAULT_TX = 8'hFF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_t;

  // MSB-first shift: drop the top bit, append a new LSB.
  function automatic logic [SPI_BYTE_W-1:0] spi_shl(
    input logic [SPI_BYTE_W-1:0] v,
    input logic                  b
  );
    return {v[SPI_BYTE_W-2:0], b};
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous SPI line, plus a third flop
// so a single-cycle rise/fall pulse can be derived in the clk domain.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Metastability stages followed by the previous-value stage for edge detect.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;
  assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/spi_slave_byte.sv
// Byte-oriented SPI mode-0 slave, MSB first, oversampled on clk_i.
// Received bytes leave as a one-cycle rx_valid_o strobe; TX bytes come in
// through a single-entry valid/ready buffer.
// Build option: define SPI_SLAVE_ECHO_EN to send the last received byte
// instead of DEFAULT_TX whenever no TX byte is buffered at load time.
module spi_slave_byte
  import spi_pkg::*;
#(
  parameter logic [SPI_BYTE_W-1:0] DEFAULT_TX   = SPI_DEFAULT_TX,
  parameter int                    IDLE_TIMEOUT = 64,
  parameter int                    TO_W         = 7
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  spi_clk_i,
  input  logic                  spi_cs_n_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  input  logic [SPI_BYTE_W-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [SPI_BYTE_W-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  busy_o
);

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(IDLE_TIMEOUT);

  // Saturating increment for the idle counter.
  function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
    return (v == TO_MAX) ? v : v + 1'b1;
  endfunction

  logic w_clk_lvl, w_clk_rise, w_clk_fall;
  logic w_cs_lvl, w_cs_rise, w_cs_fall;

  logic                  r_mosi_meta;
  logic                  r_mosi_sync;
  spi_state_t            r_state;
  logic [2:0]            r_bit_cnt;
  logic [SPI_BYTE_W-1:0] r_rx_shift;
  logic [SPI_BYTE_W-1:0] r_tx_shift;
  logic                  r_miso;
  logic [SPI_BYTE_W-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic                  r_done;
  logic [SPI_BYTE_W-1:0] r_tx_buf;
  logic                  r_tx_full;
  logic [TO_W-1:0]       r_idle_cnt;
  logic                  r_init;

  logic                  w_abort;
  logic                  w_start;
  logic                  w_rise_ok;
  logic                  w_fall_ok;
  logic                  w_timeout;
  logic                  w_load;
  logic                  w_wr;
  logic [SPI_BYTE_W-1:0] w_fill;
  logic [SPI_BYTE_W-1:0] w_load_val;

  spi_sync_edge #(.RST_VAL(SPI_CPOL)) u_clk_sync (
    .i_clk   (clk_i),
    .i_rst_n (rstn_i),
    .i_async (spi_clk_i),
    .o_level (w_clk_lvl),
    .o_rise  (w_clk_rise),
    .o_fall  (w_clk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .i_clk   (clk_i),
    .i_rst_n (rstn_i),
    .i_async (spi_cs_n_i),
    .o_level (w_cs_lvl),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  // MOSI only needs a level, aligned with the synchronised clock level.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
    end else begin
      r_mosi_meta <= spi_mosi_i;
      r_mosi_sync <= r_mosi_meta;
    end
  end

`ifdef SPI_SLAVE_ECHO_EN
  assign w_fill = r_rx_data;
`else
  assign w_fill = DEFAULT_TX;
`endif

  // Event decode; chip-select deassertion outranks any clock edge.
  always_comb begin
    w_abort    = w_cs_rise | w_cs_lvl;
    w_start    = !w_abort && w_cs_fall;
    w_rise_ok  = !w_abort && !w_cs_fall && w_clk_rise;
    w_fall_ok  = !w_abort && !w_cs_fall && w_clk_fall && (r_state == ST_SHIFT);
    w_timeout  = !w_abort && !w_cs_fall && !w_clk_rise && !w_clk_fall &&
                 (r_idle_cnt == TO_MAX) && (r_bit_cnt != 3'd0);
    w_load     = r_init || w_start || w_timeout || (w_fall_ok && (r_bit_cnt == 3'd0));
    w_wr       = tx_valid_i && !r_tx_full;
    w_load_val = r_tx_full ? r_tx_buf : w_fill;
  end

  // Frame state, bit counter and receive shift register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 3'd0;
      r_rx_shift <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_rise_ok && (r_bit_cnt == 3'd7);
      if (w_abort) begin
        r_state   <= ST_IDLE;
        r_bit_cnt <= 3'd0;
      end else if (w_start) begin
        r_state   <= ST_SHIFT;
        r_bit_cnt <= 3'd0;
      end else if (w_rise_ok) begin
        r_state    <= ST_SHIFT;
        r_rx_shift <= spi_shl(r_rx_shift, r_mosi_sync);
        r_bit_cnt  <= r_bit_cnt + 3'd1;
      end else if (w_timeout) begin
        r_state   <= ST_IDLE;
        r_bit_cnt <= 3'd0;
      end
    end
  end

  // Publish a completed byte one cycle after the counter wraps.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= r_done;
      if (r_done) begin
        r_rx_data <= r_rx_shift;
      end
    end
  end

  // Transmit shifter: load at frame start/byte boundary, shift on falling edges.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_tx_shift <= '0;
      r_miso     <= 1'b1;
      r_init     <= 1'b1;
    end else begin
      r_init <= 1'b0;
      if (w_load) begin
        r_tx_shift <= w_load_val;
        r_miso     <= w_load_val[SPI_BYTE_W-1];
      end else if (w_fall_ok) begin
        r_tx_shift <= spi_shl(r_tx_shift, 1'b0);
        r_miso     <= r_tx_shift[SPI_BYTE_W-2];
      end
    end
  end

  // Single-entry TX buffer; a load consumes the old content even if refilled.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_tx_buf  <= '0;
      r_tx_full <= 1'b0;
    end else if (w_wr) begin
      r_tx_buf  <= tx_data_i;
      r_tx_full <= 1'b1;
    end else if (w_load) begin
      r_tx_full <= 1'b0;
    end
  end

  // Idle counter: counts clk_i cycles with SPI clock low and no edge.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_idle_cnt <= '0;
    end else if (w_clk_rise || w_clk_fall || w_clk_lvl) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= sat_inc(r_idle_cnt);
    end
  end

  assign spi_miso_o = r_miso;
  assign tx_ready_o = !r_tx_full;
  assign rx_data_o  = r_rx_data;
  assign rx_valid_o = r_rx_valid;
  assign busy_o     = (r_bit_cnt != 3'd0);

endmodule

// File: tb/tb_spi_slave_byte.sv
// Bench for spi_slave_byte: a behavioural mode-0 master drives frames,
// received bytes are checked through a scoreboard queue.
module tb_spi_slave_byte;

  localparam int HALF = 100;

  logic       clk;
  logic       rstn;
  logic       spi_clk;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;

  int         n_cmp = 0;
  int         n_mis = 0;
  int         n_rxv = 0;
  logic [7:0] sb_q[$];
  logic [7:0] exp_rx;
  logic [7:0] m_last_rx = 8'h00;
  logic [7:0] got;

  spi_slave_byte dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .spi_clk_i  (spi_clk),
    .spi_cs_n_i (spi_cs_n),
    .spi_mosi_i (spi_mosi),
    .spi_miso_o (spi_miso),
    .tx_data_i  (tx_data),
    .tx_valid_i (tx_valid),
    .tx_ready_o (tx_ready),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Byte the slave should send when nothing was pushed.
  function automatic logic [7:0] dflt();
`ifdef SPI_SLAVE_ECHO_EN
    return m_last_rx;
`else
    return 8'hFF;
`endif
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      #HALF;
      spi_clk = 1'b1;
      rx = {rx[6:0], spi_miso};
      #HALF;
      spi_clk = 1'b0;
    end
  endtask

  task automatic frame_byte(input logic [7:0] mosi_b, input logic [7:0] exp_miso, input string tag);
    logic [7:0] r;
    sb_q.push_back(mosi_b);
    spi_xfer(mosi_b, 8, r);
    check(tag, r, exp_miso);
    m_last_rx = mosi_b;
  endtask

  task automatic tx_push(input logic [7:0] b);
    int t;
    t = 0;
    while (!tx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("push_ready", tx_ready, 1'b1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Scoreboard: every rx strobe must match the oldest outstanding byte.
  always @(negedge clk) begin
    if (rstn && rx_valid) begin
      n_rxv++;
      if (sb_q.size() == 0) begin
        check("rx_unexp", rx_valid, 1'b0);
      end else begin
        exp_rx = sb_q.pop_front();
        check("rx_byte", rx_data, exp_rx);
      end
    end
  end

  initial begin
    rstn     = 1'b0;
    spi_clk  = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;

    #50;
    check("rst_busy_in", busy, 1'b0);
    check("rst_rxv_in", rx_valid, 1'b0);
    #50;
    rstn = 1'b1;
    wait_clk(5);
    check("rst_miso", spi_miso, dflt() >> 7);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_rxd", rx_data, 8'h00);
    check("rst_rxv", rx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);

    // Single byte, nothing pushed.
    spi_cs_n = 1'b0;
    wait_clk(10);
    frame_byte(8'hA5, dflt(), "miso_a5");
    wait_clk(10);
    check("a5_busy", busy, 1'b0);
    check("a5_rxd", rx_data, 8'hA5);
    spi_cs_n = 1'b1;
    wait_clk(10);

    // Pushed TX byte consumed at frame start.
    tx_push(8'h3C);
    check("txbuf_full", tx_ready, 1'b0);
    spi_cs_n = 1'b0;
    wait_clk(10);
    check("txbuf_drain", tx_ready, 1'b1);
    frame_byte(8'h96, 8'h3C, "miso_3c");
    wait_clk(10);
    spi_cs_n = 1'b1;
    wait_clk(10);

    // Back-to-back bytes in one frame.
    spi_cs_n = 1'b0;
    wait_clk(10);
    frame_byte(8'h01, dflt(), "miso_b2b0");
    frame_byte(8'h80, dflt(), "miso_b2b1");
    wait_clk(10);
    spi_cs_n = 1'b1;
    wait_clk(10);

    // Chip select raised mid-byte, then a clean byte.
    spi_cs_n = 1'b0;
    wait_clk(10);
    spi_xfer(8'hFF, 5, got);
    wait_clk(3);
    check("part_busy", busy, 1'b1);
    spi_cs_n = 1'b1;
    wait_clk(10);
    check("abort_busy", busy, 1'b0);
    spi_cs_n = 1'b0;
    wait_clk(10);
    frame_byte(8'h5A, dflt(), "miso_5a");
    wait_clk(10);
    spi_cs_n = 1'b1;
    wait_clk(10);

    // Clock stalls mid-byte with chip select held low: idle timeout resync.
    spi_cs_n = 1'b0;
    wait_clk(10);
    spi_xfer(8'hE0, 3, got);
    wait_clk(5);
    check("stall_busy", busy, 1'b1);
    wait_clk(100);
    check("to_busy", busy, 1'b0);
    check("to_miso", spi_miso, dflt() >> 7);
    frame_byte(8'hC3, dflt(), "miso_c3");
    wait_clk(10);
    check("c3_rxd", rx_data, 8'hC3);
    spi_cs_n = 1'b1;
    wait_clk(10);

    // Asynchronous reset in the middle of a byte.
    spi_cs_n = 1'b0;
    wait_clk(10);
    spi_xfer(8'hF0, 4, got);
    rstn = 1'b0;
    #1;
    check("mrst_busy", busy, 1'b0);
    check("mrst_rxd", rx_data, 8'h00);
    check("mrst_rxv", rx_valid, 1'b0);
    check("mrst_ready", tx_ready, 1'b1);
    spi_cs_n = 1'b1;
    wait_clk(3);
    rstn = 1'b1;
    wait_clk(10);

    check("sb_empty", sb_q.size(), 0);
    check("rx_count", n_rxv, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
